// File: rtl/anton_neopixel_stream_logic.sv
// NeoPixel stream sequencer: walks pixel / channel / bit / pattern-slot
// indexes through frames of transmit slots followed by a low latch period.
//
// syncStart is a single-cycle request with no ready: it is accepted only
// when the sequencer is IDLE and regCtrlRun is high, and is dropped otherwise.

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef ENUM_STATE_TRANSMIT
`define ENUM_STATE_TRANSMIT 1'b1
`endif
`ifndef ENUM_STATE_RESET
`define ENUM_STATE_RESET 1'b0
`endif

module anton_neopixel_stream_logic #(
    parameter int unsigned BUFFER_END   = `BUFFER_END_DEFAULT,
    parameter int unsigned RESET_CYCLES = 400,
    localparam int unsigned BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
    input  logic                   clk6_4mhz,
    input  logic                   rstn,
    input  logic                   regCtrlInit,
    input  logic                   regCtrlRun,
    input  logic                   regCtrlLoop,
    input  logic                   regCtrl32bit,
    input  logic [BUFFER_BITS-1:0] regPixelsMax,
    input  logic                   syncStart,
    output logic                   state,
    output logic [BUFFER_BITS-1:0] pixelIndex,
    output logic [2:0]             pixelBitIndex,
    output logic [1:0]             channelIndex,
    output logic [2:0]             bitPatternIndex,
    output logic                   streamDone,
    output logic                   busy
);

    localparam int unsigned W  = BUFFER_BITS;
    localparam int unsigned DW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [W-1:0]  END_ADDR = W'(BUFFER_END);
    localparam logic [DW-1:0] DLY_LAST = DW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TX   = 2'd1,
        S_RST  = 2'd2
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [W-1:0]  pix_q, pix_d;
    logic [2:0]    pbit_q, pbit_d;
    logic [1:0]    chan_q, chan_d;
    logic [2:0]    bpat_q, bpat_d;
    logic [DW-1:0] delay_q, delay_d;
    logic          done_q, done_d;
    logic          mode32_q, mode32_d;
    logic [W-1:0]  last_q, last_d;

    logic          last_slot;
    logic          last_pix;
    logic          dly_end;
    logic [W-1:0]  clamp_addr;
    logic [W-1:0]  pix_next;

    // Frame-level decodes shared by the next-state and datapath logic
    always_comb begin
        last_slot  = (chan_q == 2'd2) && (pbit_q == 3'd7) && (bpat_q == 3'd7);
        last_pix   = mode32_q ? (pix_q[W-1:2] == last_q[W-1:2]) : (pix_q == last_q);
        dly_end    = (delay_q == DLY_LAST);
        clamp_addr = (regPixelsMax > END_ADDR) ? END_ADDR : regPixelsMax;
        pix_next   = mode32_q ? ((pix_q + W'(4)) & ~W'(3)) : (pix_q + W'(1));
    end

    // State register
    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) fsm_q <= S_IDLE;
        else       fsm_q <= fsm_d;
    end

    // Next-state logic; Init overrides everything
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE: if (syncStart && regCtrlRun) fsm_d = S_TX;
            S_TX: begin
                if (!regCtrlRun)            fsm_d = S_RST;
                else if (last_slot && last_pix) fsm_d = S_RST;
            end
            S_RST: if (dly_end) fsm_d = (regCtrlLoop && regCtrlRun) ? S_TX : S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
        if (regCtrlInit) fsm_d = S_IDLE;
    end

    // Output/datapath next values: index stepping, latch counter, frame latches
    always_comb begin
        pix_d    = pix_q;
        pbit_d   = pbit_q;
        chan_d   = chan_q;
        bpat_d   = bpat_q;
        delay_d  = delay_q;
        mode32_d = mode32_q;
        last_d   = last_q;
        done_d   = 1'b0;
        if (regCtrlInit) begin
            pix_d   = '0;
            pbit_d  = '0;
            chan_d  = '0;
            bpat_d  = '0;
            delay_d = '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    pix_d   = '0;
                    pbit_d  = '0;
                    chan_d  = '0;
                    bpat_d  = '0;
                    delay_d = '0;
                    if (fsm_d == S_TX) begin
                        mode32_d = regCtrl32bit;
                        last_d   = clamp_addr;
                    end
                end
                S_TX: begin
                    if (fsm_d == S_RST) begin
                        pix_d   = '0;
                        pbit_d  = '0;
                        chan_d  = '0;
                        bpat_d  = '0;
                        delay_d = '0;
                    end else begin
                        bpat_d = bpat_q + 3'd1;
                        if (bpat_q == 3'd7) pbit_d = pbit_q + 3'd1;
                        if (bpat_q == 3'd7 && pbit_q == 3'd7)
                            chan_d = (chan_q == 2'd2) ? 2'd0 : chan_q + 2'd1;
                        if (last_slot) pix_d = pix_next;
                    end
                end
                S_RST: begin
                    pix_d  = '0;
                    pbit_d = '0;
                    chan_d = '0;
                    bpat_d = '0;
                    if (dly_end) begin
                        delay_d = '0;
                        if (fsm_d == S_TX) begin
                            mode32_d = regCtrl32bit;
                            last_d   = clamp_addr;
                        end
                    end else begin
                        delay_d = delay_q + DW'(1);
                    end
                end
                default: ;
            endcase
        end
        done_d = (fsm_d == S_RST) && (delay_d == DLY_LAST);
    end

    // Datapath registers
    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            pix_q    <= '0;
            pbit_q   <= '0;
            chan_q   <= '0;
            bpat_q   <= '0;
            delay_q  <= '0;
            done_q   <= 1'b0;
            mode32_q <= 1'b0;
            last_q   <= '0;
        end else begin
            pix_q    <= pix_d;
            pbit_q   <= pbit_d;
            chan_q   <= chan_d;
            bpat_q   <= bpat_d;
            delay_q  <= delay_d;
            done_q   <= done_d;
            mode32_q <= mode32_d;
            last_q   <= last_d;
        end
    end

    assign state           = (fsm_q == S_TX) ? `ENUM_STATE_TRANSMIT : `ENUM_STATE_RESET;
    assign busy            = (fsm_q != S_IDLE);
    assign pixelIndex      = pix_q;
    assign pixelBitIndex   = pbit_q;
    assign channelIndex    = chan_q;
    assign bitPatternIndex = bpat_q;
    assign streamDone      = done_q;

endmodule

// File: tb/tb_anton_neopixel_stream_logic.sv
// Bench for the NeoPixel stream sequencer: table of single-shot frames plus
// hand-written loop, abort, Init and async-reset sequences.

module tb_anton_neopixel_stream_logic;

    localparam int BE = 10;
    localparam int RC = 400;
    localparam int W  = $clog2(BE + 1);

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         init, run, loop, m32, sync;
    logic [W-1:0] pmax;
    logic         state, done, busy;
    logic [W-1:0] pix;
    logic [2:0]   pbit, bpat;
    logic [1:0]   chan;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic         is32;
        logic [W-1:0] pmax;
        logic         chg;
        int           exp_tx;
        int           exp_last;
    } vec_t;

    vec_t tbl[7];

    anton_neopixel_stream_logic #(.BUFFER_END(BE), .RESET_CYCLES(RC)) dut (
        .clk6_4mhz(clk),
        .rstn(rstn),
        .regCtrlInit(init),
        .regCtrlRun(run),
        .regCtrlLoop(loop),
        .regCtrl32bit(m32),
        .regPixelsMax(pmax),
        .syncStart(sync),
        .state(state),
        .pixelIndex(pix),
        .pixelBitIndex(pbit),
        .channelIndex(chan),
        .bitPatternIndex(bpat),
        .streamDone(done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int idx_sum();
        return int'(pix) + int'(pbit) + int'(chan) + int'(bpat);
    endfunction

    task automatic pulse_start(input logic is32, input logic [W-1:0] mx, input logic lp);
        @(negedge clk);
        m32 = is32; pmax = mx; run = 1'b1; loop = lp; sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    // One single-shot frame, checked against a cycle-count model of the indexes
    task automatic run_frame(input vec_t v);
        int tx, last, seq_err, done_tx, rc, dcnt, dpos, rerr;
        int step;
        step = v.is32 ? 4 : 1;
        pulse_start(v.is32, v.pmax, 1'b0);
        tx = 0; last = -1; seq_err = 0; done_tx = 0;
        while (state == 1'b1 && tx < 5000) begin
            if (int'(bpat) != tx % 8 || int'(pbit) != (tx / 8) % 8 ||
                int'(chan) != (tx / 64) % 3 || int'(pix) != (tx / 192) * step)
                seq_err++;
            if (done) done_tx++;
            last = int'(pix);
            if (v.chg && tx == 100) begin
                m32  = ~v.is32;
                pmax = v.is32 ? W'(15) : W'(0);
            end
            tx++;
            @(negedge clk);
        end
        check("tx_len", tx, v.exp_tx);
        check("last_pix", last, v.exp_last);
        check("idx_seq", seq_err, 0);
        check("done_in_tx", done_tx, 0);
        rc = 0; dcnt = 0; dpos = -1; rerr = 0;
        while (busy && state == 1'b0 && rc < 1000) begin
            if (done) begin dcnt++; dpos = rc; end
            if (idx_sum() != 0) rerr++;
            rc++;
            @(negedge clk);
        end
        check("rst_len", rc, RC);
        check("done_cnt", dcnt, 1);
        check("done_pos", dpos, RC - 1);
        check("idx_in_rst", rerr, 0);
        check("busy_end", int'(busy), 0);
    endtask

    initial begin
        tbl[0] = '{is32: 1'b0, pmax: W'(2),  chg: 1'b0, exp_tx: 576,  exp_last: 2};
        tbl[1] = '{is32: 1'b1, pmax: W'(7),  chg: 1'b0, exp_tx: 384,  exp_last: 4};
        tbl[2] = '{is32: 1'b1, pmax: W'(6),  chg: 1'b0, exp_tx: 384,  exp_last: 4};
        tbl[3] = '{is32: 1'b0, pmax: W'(15), chg: 1'b0, exp_tx: 2112, exp_last: 10};
        tbl[4] = '{is32: 1'b1, pmax: W'(15), chg: 1'b0, exp_tx: 576,  exp_last: 8};
        tbl[5] = '{is32: 1'b0, pmax: W'(2),  chg: 1'b1, exp_tx: 576,  exp_last: 2};
        tbl[6] = '{is32: 1'b1, pmax: W'(7),  chg: 1'b1, exp_tx: 384,  exp_last: 4};

        init = 1'b0; run = 1'b0; loop = 1'b0; m32 = 1'b0; sync = 1'b0; pmax = '0;

        // Clock/reset
        #1 rstn = 1'b0;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_idx", idx_sum(), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Table-driven single-shot frames
        for (int i = 0; i < 7; i++) run_frame(tbl[i]);

        // Loop mode: repeating 192/400 frames, then clear Loop mid-TRANSMIT
        begin
            int c, p1, p2, dcnt, n;
            pulse_start(1'b0, W'(0), 1'b1);
            c = 0; p1 = -1; p2 = -1;
            while (p2 < 0 && c < 2000) begin
                if (done) begin
                    if (p1 < 0) p1 = c; else p2 = c;
                end
                c++;
                @(negedge clk);
            end
            check("loop_first_done", p1, 591);
            check("loop_period", p2 - p1, 592);
            check("loop_restart", int'(state), 1);
            repeat (10) @(negedge clk);
            loop = 1'b0;
            dcnt = 0; n = 0;
            while (busy && n < 1000) begin
                if (done) dcnt++;
                n++;
                @(negedge clk);
            end
            check("loop_stop_done", dcnt, 1);
            check("loop_stop_len", n, 182 + RC);
            check("loop_stop_idle", int'(busy), 0);
        end

        // Abort: drop Run at cycle 100 of TRANSMIT; syncStart in RESET ignored
        begin
            int rc, dcnt;
            pulse_start(1'b0, W'(2), 1'b0);
            repeat (100) @(negedge clk);
            run = 1'b0;
            @(negedge clk);
            check("abort_state", int'(state), 0);
            check("abort_busy", int'(busy), 1);
            check("abort_idx", idx_sum(), 0);
            rc = 0; dcnt = 0;
            while (busy && rc < 1000) begin
                if (done) dcnt++;
                if (rc == 10) begin run = 1'b1; sync = 1'b1; end
                if (rc == 11) sync = 1'b0;
                rc++;
                @(negedge clk);
            end
            check("abort_rst_len", rc, RC);
            check("abort_done", dcnt, 1);
            repeat (5) @(negedge clk);
            check("abort_idle", int'(busy), 0);
        end

        // Init mid-TRANSMIT: synchronous clear, no streamDone
        begin
            int dcnt, bcnt;
            pulse_start(1'b0, W'(2), 1'b0);
            repeat (50) @(negedge clk);
            init = 1'b1;
            @(negedge clk);
            check("init_state", int'(state), 0);
            check("init_busy", int'(busy), 0);
            check("init_idx", idx_sum(), 0);
            check("init_done", int'(done), 0);
            init = 1'b0;
            dcnt = 0; bcnt = 0;
            repeat (500) begin
                if (done) dcnt++;
                if (busy) bcnt++;
                @(negedge clk);
            end
            check("init_no_done", dcnt, 0);
            check("init_stay_idle", bcnt, 0);
        end

        // Asynchronous rstn mid-TRANSMIT
        begin
            int dcnt, bcnt;
            pulse_start(1'b1, W'(7), 1'b0);
            repeat (50) @(negedge clk);
            #2 rstn = 1'b0;
            #1;
            check("arst_state", int'(state), 0);
            check("arst_busy", int'(busy), 0);
            check("arst_idx", idx_sum(), 0);
            check("arst_done", int'(done), 0);
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            dcnt = 0; bcnt = 0;
            repeat (500) begin
                if (done) dcnt++;
                if (busy) bcnt++;
                @(negedge clk);
            end
            check("arst_no_done", dcnt, 0);
            check("arst_stay_idle", bcnt, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
